fmul_sched: RTL and testbench
=============================

// Module: fmul_sched
// PURPOSE
//  Shares one pipelined fmul between NREQ requesters (e.g. FPU issue ports).
//  Round-robin grants at most one operand pair per cycle (sustained 1 op/clk) and
//  tracks each grant's requester ID through the fmul latency.
//  Routes each product back to its originator. Sits between FPU issue logic and the fmul.
// PARAMETERS
//  NREQ  4  number of requesters, 2..8
//  LAT   2  fmul latency in clocks; passed to the fmul NSTAGE parameter
// PORTS
//  clk        in   1        clock; all state updates on posedge
//  rstn       in   1        reset, asynchronous, active-low
//  req_valid  in   NREQ     requester i has an operand pair pending
//  req_x1     in   NREQ*32  operand 1 of requester i at bits [32i+31:32i]
//  req_x2     in   NREQ*32  operand 2 of requester i, same packing
//  req_ready  out  NREQ     one-hot grant; a handshake fires when valid&ready
//  resp_valid out  NREQ     one-hot; product for requester i on resp_y this cycle
//  resp_y     out  32       IEEE-754 single product
//  resp_ovf   out  1        exponent overflow for this product (FMUL_SCHED_OVF_EN only)
//  busy       out  1        at least one operation in flight
// BEHAVIOUR
//  Reset: req_ready, resp_valid, resp_y, resp_ovf and busy are 0. rr_ptr=0.
//   In-flight valid/ID pipeline cleared asynchronously; in-flight ops are dropped and never returned.
//  Arbitration (combinational): scan req_valid from rr_ptr upward, wrapping at NREQ; first hit gets req_ready.
//   req_ready=0 for all while rstn=0.
//  rr_ptr: after a grant to i, rr_ptr <= (i+1) mod NREQ. With no grant it holds. Wrap NREQ-1 -> 0.
//  Requester rules: req_valid and operands stay stable until the handshake. req_ready never depends on resp.
//  Issue: granted operands muxed to fmul x1/x2; with no grant both are driven 32'h0.
//  Tracking: LAT-deep shift register of {valid, id[$clog2(NREQ)-1:0]}, advanced every clock.
//  Response: a handshake in cycle t yields resp_valid[id]=1 in cycle t+LAT, with resp_y = fmul y.
//   resp_y = 0 when no resp_valid bit is set.
//  No response back-pressure: requesters accept results unconditionally. The fmul cannot stall.
//  Simultaneous events: a grant and a response in the same cycle, including for the same requester, are both legal and independent.
//  Back-to-back grants to one requester are legal when it is the only one valid.
//  Arithmetic: truncating fmul semantics. Zero exponent on either operand -> signed zero.
//   Exponent overflow -> exponent 255, mantissa 0.
//  busy = OR of the tracking-pipeline valid bits.
// CONFIGURATION
//  FMUL_SCHED_OVF_EN defined: fmul ovf asserts one clock before its y.
//   It is delayed by one register so resp_ovf aligns with resp_valid, and is 0 when no response is valid.
//  FMUL_SCHED_OVF_EN undefined: resp_ovf tied 0 and the alignment register is removed.
// STRUCTURE
//  Shared package fpu_pkg: FP_W=32, FP_EXP_MAX=8'hFF, FP_ZERO=32'h0, and a function req_id_w(n)=$clog2(n).
//  Sub-module: one fmul instance (NSTAGE=LAT) with clk and rstn wired through. The arbiter stays inline.
// TESTING
//  Single op: req0 0x40000000 x 0x40400000 at t -> resp_valid=4'b0001 at t+2, resp_y=0x40C00000.
//  All 4 valid for 8 cycles -> grants in order 0,1,2,3,0,1,2,3, one per cycle.
//   Responses follow the same order, 2 cycles later.
//  Sign and exactness: req2 0xBFC00000 x 0x3FC00000 -> resp_valid[2], resp_y=0xC0100000.
//   req1 0x00000000 x 0x40400000 -> resp_y=0x00000000.
//  Overflow: 0x7F000000 x 0x7F000000 -> resp_y=0x7F800000.
//   resp_ovf=1 with the macro defined, 0 without.
//  Reset mid-flight: grant at t, rstn low at t+1 -> no resp_valid at t+2, busy=0, rr_ptr=0.
//   First grant after reset goes to req0.
//  Wrap: only req3 valid -> granted; then req0 and req3 both valid -> req0 granted first.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared floating-point constants and helpers for the fmul scheduler slice.
package fpu_pkg;
  localparam int         FP_W       = 32;
  localparam logic [7:0] FP_EXP_MAX = 8'hFF;
  localparam logic [31:0] FP_ZERO   = 32'h0;

  function automatic int req_id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/fmul_sched_if.sv
// Requester-side bus of the shared fmul scheduler: operand issue and product return.
interface fmul_sched_if
  import fpu_pkg::*;
#(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*FP_W-1:0] req_x1;
  logic [NREQ*FP_W-1:0] req_x2;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      resp_valid;
  logic [FP_W-1:0]      resp_y;
  logic                 resp_ovf;
  logic                 busy;

  modport master (
    output req_valid, req_x1, req_x2,
    input  req_ready, resp_valid, resp_y, resp_ovf, busy
  );

  modport slave (
    input  req_valid, req_x1, req_x2,
    output req_ready, resp_valid, resp_y, resp_ovf, busy
  );
endinterface

// File: rtl/fmul_sched_fmul.sv
// Truncating IEEE-754 single multiplier, NSTAGE clocks deep; ovf leaves one clock ahead of y.
module fmul_sched_fmul
  import fpu_pkg::*;
#(
  parameter int NSTAGE = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [FP_W-1:0] i_x1,
  input  logic [FP_W-1:0] i_x2,
  output logic [FP_W-1:0] o_y,
  output logic            o_ovf
);

  // Returns {ovf, word}: saturates to infinity on overflow, flushes underflow to signed zero.
  function automatic logic [FP_W:0] fp_pack(input logic sgn, input logic signed [9:0] exp,
                                            input logic [22:0] frac);
    if (exp >= 10'sd255)    return {1'b1, sgn, FP_EXP_MAX, 23'b0};
    else if (exp <= 10'sd0) return {1'b0, sgn, 31'b0};
    else                    return {1'b0, sgn, exp[7:0], frac};
  endfunction

  logic [47:0]       w_prod;
  logic signed [9:0] w_exp;
  logic [22:0]       w_frac;
  logic              w_sgn;
  logic              w_zero;
  logic [FP_W:0]     w_res;
  logic              w_unused_lo;

  always_comb begin
    w_sgn  = i_x1[31] ^ i_x2[31];
    w_zero = (i_x1[30:23] == 8'h0) || (i_x2[30:23] == 8'h0);
    w_prod = {24'b0, 1'b1, i_x1[22:0]} * {24'b0, 1'b1, i_x2[22:0]};
    w_frac = w_prod[47] ? w_prod[46:24] : w_prod[45:23];
    w_exp  = $signed({2'b00, i_x1[30:23]}) + $signed({2'b00, i_x2[30:23]})
           + $signed({9'b0, w_prod[47]}) - 10'sd127;
    w_res  = w_zero ? {1'b0, w_sgn, 31'b0} : fp_pack(w_sgn, w_exp, w_frac);
  end

  assign w_unused_lo = |w_prod[22:0];

  // p0 .. pN-1: product pipeline
  logic [FP_W-1:0] r_y_p [NSTAGE];

  always_ff @(posedge clk) begin
    r_y_p[0] <= w_res[FP_W-1:0];
    for (int s = 1; s < NSTAGE; s++) r_y_p[s] <= r_y_p[s-1];
  end

  assign o_y = r_y_p[NSTAGE-1];

  if (NSTAGE == 1) begin : g_ovf_comb
    assign o_ovf = w_res[FP_W];
  end else begin : g_ovf_pipe
    logic [NSTAGE-2:0] r_ovf_p;
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_ovf_p <= '0;
      end else begin
        r_ovf_p[0] <= w_res[FP_W];
        for (int s = 1; s < NSTAGE - 1; s++) r_ovf_p[s] <= r_ovf_p[s-1];
      end
    end
    assign o_ovf = r_ovf_p[NSTAGE-2];
  end

endmodule

// File: rtl/fmul_sched.sv
// Round-robin sharing of one pipelined fmul among NREQ requesters, with ID tracking for returns.
// Optional FMUL_SCHED_OVF_EN: exposes an exponent-overflow flag aligned with resp_valid.
module fmul_sched
  import fpu_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT  = 2
) (
  input  logic         clk,
  input  logic         rstn,
  fmul_sched_if.slave  bus
);

  localparam int IDW = req_id_w(NREQ);

  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  w_gid;
  logic [NREQ-1:0] w_gnt;
  logic            w_fire;
  logic [FP_W-1:0] w_x1;
  logic [FP_W-1:0] w_x2;
  logic [FP_W-1:0] w_y;
  logic            w_ovf;

  // First valid requester at or above the pointer, wrapping, wins.
  always_comb begin
    w_gnt  = '0;
    w_gid  = '0;
    w_fire = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_fire && bus.req_valid[(int'(r_rr_ptr) + k) % NREQ]) begin
        w_fire = 1'b1;
        w_gid  = IDW'((int'(r_rr_ptr) + k) % NREQ);
      end
    end
    if (!rstn) w_fire = 1'b0;
    if (w_fire) w_gnt[w_gid] = 1'b1;
  end

  assign bus.req_ready = w_gnt;
  assign w_x1 = w_fire ? bus.req_x1[w_gid*FP_W +: FP_W] : FP_ZERO;
  assign w_x2 = w_fire ? bus.req_x2[w_gid*FP_W +: FP_W] : FP_ZERO;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       r_rr_ptr <= '0;
    else if (w_fire) r_rr_ptr <= (int'(w_gid) == NREQ - 1) ? '0 : w_gid + 1'b1;
  end

  fmul_sched_fmul #(.NSTAGE(LAT)) u_fmul (
    .clk   (clk),
    .rstn  (rstn),
    .i_x1  (w_x1),
    .i_x2  (w_x2),
    .o_y   (w_y),
    .o_ovf (w_ovf)
  );

  // p0 .. pLAT-1: grant tracking alongside the fmul pipeline
  logic [LAT-1:0] r_vld_p;
  logic [IDW-1:0] r_id_p [LAT];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld_p <= '0;
    end else begin
      r_vld_p[0] <= w_fire;
      for (int s = 1; s < LAT; s++) r_vld_p[s] <= r_vld_p[s-1];
    end
  end

  always_ff @(posedge clk) begin
    r_id_p[0] <= w_gid;
    for (int s = 1; s < LAT; s++) r_id_p[s] <= r_id_p[s-1];
  end

  logic [NREQ-1:0] w_resp_vld;

  always_comb begin
    w_resp_vld = '0;
    if (r_vld_p[LAT-1]) w_resp_vld[r_id_p[LAT-1]] = 1'b1;
  end

  assign bus.resp_valid = w_resp_vld;
  assign bus.resp_y     = r_vld_p[LAT-1] ? w_y : FP_ZERO;
  assign bus.busy       = |r_vld_p;

`ifdef FMUL_SCHED_OVF_EN
  logic r_ovf_al;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_ovf_al <= 1'b0;
    else       r_ovf_al <= w_ovf;
  end
  assign bus.resp_ovf = r_vld_p[LAT-1] & r_ovf_al;
`else
  logic w_unused_ovf;
  assign w_unused_ovf = w_ovf;
  assign bus.resp_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_fmul_sched.sv
// Directed bench for fmul_sched: arbitration order, product routing/values, overflow flag, reset.
module tb_fmul_sched;

  localparam int NREQ = 4;
  localparam int LAT  = 2;
  localparam int NP   = 11;

`ifdef FMUL_SCHED_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fmul_sched_if #(.NREQ(NREQ)) bus ();

  fmul_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct packed {
    logic [3:0]  vld;
    logic [31:0] y;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] pa [NP];
  logic [31:0] pb [NP];
  logic [31:0] pp [NP];
  logic        po [NP];
  logic [31:0] slot_y   [NREQ];
  logic        slot_ovf [NREQ];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
    end
  endtask

  task automatic load(input int i, input int p);
    bus.req_x1[i*32 +: 32] = pa[p];
    bus.req_x2[i*32 +: 32] = pb[p];
    bus.req_valid[i]       = 1'b1;
    slot_y[i]              = pp[p];
    slot_ovf[i]            = po[p];
  endtask

  // One clock: check grant, busy and any due response at negedge, then advance.
  task automatic step(input logic [3:0] exp_rdy, input string tag);
    exp_t        e;
    logic [3:0]  fired;
    logic [3:0]  ev;
    logic [31:0] ey;
    logic        eo;
    @(negedge clk);
    chk({tag, "/ready"}, 32'(bus.req_ready), 32'(exp_rdy));
    chk({tag, "/busy"}, 32'(bus.busy), 32'(sb.size() != 0));
    ev = '0; ey = '0; eo = 1'b0;
    if (sb.size() != 0 && sb[0].due == cyc) begin
      e  = sb.pop_front();
      ev = e.vld; ey = e.y; eo = e.ovf;
    end
    chk({tag, "/resp_valid"}, 32'(bus.resp_valid), 32'(ev));
    chk({tag, "/resp_y"}, bus.resp_y, ey);
    chk({tag, "/resp_ovf"}, 32'(bus.resp_ovf), 32'(eo));
    fired = exp_rdy & bus.req_valid;
    for (int i = 0; i < NREQ; i++) begin
      if (fired[i]) begin
        e.vld = 4'(1 << i);
        e.y   = slot_y[i];
        e.ovf = slot_ovf[i];
        e.due = cyc + LAT;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    bus.req_valid = bus.req_valid & ~fired;
  endtask

  initial begin
    pa[0]  = 32'h40000000; pb[0]  = 32'h40400000; pp[0]  = 32'h40C00000; po[0]  = 1'b0;
    pa[1]  = 32'h00000000; pb[1]  = 32'h40400000; pp[1]  = 32'h00000000; po[1]  = 1'b0;
    pa[2]  = 32'hBFC00000; pb[2]  = 32'h3FC00000; pp[2]  = 32'hC0100000; po[2]  = 1'b0;
    pa[3]  = 32'h7F000000; pb[3]  = 32'h7F000000; pp[3]  = 32'h7F800000; po[3]  = OVF_ON;
    pa[4]  = 32'h3F800000; pb[4]  = 32'h3F800000; pp[4]  = 32'h3F800000; po[4]  = 1'b0;
    pa[5]  = 32'h40800000; pb[5]  = 32'h3F000000; pp[5]  = 32'h40000000; po[5]  = 1'b0;
    pa[6]  = 32'hC0000000; pb[6]  = 32'hC0000000; pp[6]  = 32'h40800000; po[6]  = 1'b0;
    pa[7]  = 32'h3FC00000; pb[7]  = 32'h3FA00000; pp[7]  = 32'h3FF00000; po[7]  = 1'b0;
    pa[8]  = 32'h3FC00001; pb[8]  = 32'h3FC00001; pp[8]  = 32'h40100001; po[8]  = 1'b0;
    pa[9]  = 32'h80000000; pb[9]  = 32'h40400000; pp[9]  = 32'h80000000; po[9]  = 1'b0;
    pa[10] = 32'hFF000000; pb[10] = 32'h7F000000; pp[10] = 32'hFF800000; po[10] = OVF_ON;

    bus.req_valid = '0;
    bus.req_x1    = '0;
    bus.req_x2    = '0;

    step(4'b0000, "rst0");
    step(4'b0000, "rst1");
    rstn = 1'b1;
    step(4'b0000, "idle");

    load(0, 0); step(4'b0001, "single");
    step(4'b0000, "single_w1");
    step(4'b0000, "single_w2");
    step(4'b0000, "single_w3");

    load(1, 1); step(4'b0010, "zero");
    load(2, 2); step(4'b0100, "sign");
    step(4'b0000, "sign_w1");
    step(4'b0000, "sign_w2");

    load(3, 4); step(4'b1000, "wrap3");
    load(0, 5); load(3, 6);
    step(4'b0001, "wrap0");
    step(4'b1000, "wrap3b");
    step(4'b0000, "wrap_w1");
    step(4'b0000, "wrap_w2");

    load(0, 7); load(1, 8); load(2, 9); load(3, 10);
    for (int k = 0; k < 8; k++) begin
      step(4'(1 << (k % 4)), "rr");
      load(k % 4, (k + 4) % NP);
    end
    bus.req_valid = '0;
    step(4'b0000, "rr_w1");
    step(4'b0000, "rr_w2");

    load(2, 3); step(4'b0100, "ovf");
    step(4'b0000, "ovf_w1");
    step(4'b0000, "ovf_w2");

    load(1, 4); step(4'b0010, "b2b0");
    load(1, 6); step(4'b0010, "b2b1");
    load(1, 8); step(4'b0010, "b2b2");
    step(4'b0000, "b2b_w1");
    step(4'b0000, "b2b_w2");

    load(0, 0); step(4'b0001, "pre_rst");
    rstn = 1'b0;
    sb.delete();
    load(0, 2); load(1, 5);
    step(4'b0000, "rst_mid1");
    step(4'b0000, "rst_mid2");
    rstn = 1'b1;
    step(4'b0001, "post_rst0");
    step(4'b0010, "post_rst1");
    step(4'b0000, "post_w1");
    step(4'b0000, "post_w2");
    step(4'b0000, "post_w3");

    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
